log2_arbiter: RTL and testbench

LOG2_ARBITER -- requirements
Module: log2_arbiter

---
 rtl/log2_arb_pkg.sv | 17 +
 rtl/log2_rr_pick.sv | 23 ++
 rtl/log2_arbiter.sv | 123 ++++++++++++
 tb/tb_log2_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/log2_arb_pkg.sv
// Shared types and constants for the log2 core arbiter.
package log2_arb_pkg;

  localparam int unsigned W_IN  = 8;
  localparam int unsigned W_OUT = 11;

  // Result reported for a zero operand; the core is bypassed.
  localparam logic [W_OUT-1:0] ZERO_RESULT = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/log2_rr_pick.sv
// Round-robin picker: first asserted request after last_grant, wrapping to 0.
module log2_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             any
);

  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!any && req[IDX_W'((32'(last_grant) + i) % N_REQ)]) begin
        grant = IDX_W'((32'(last_grant) + i) % N_REQ);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/log2_arbiter.sv
// Shares one external log2X core among N_REQ requesters, one operation at a time,
// with round-robin grant, core restart/settle sequencing and per-owner response.
module log2_arbiter
  import log2_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [W_IN*N_REQ-1:0] req_a,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [W_OUT-1:0]      rsp_o,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic                  core_rst,
  output logic [W_IN-1:0]       core_a,
  input  logic [W_OUT-1:0]      core_o,
  output logic                  busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LAT);

  state_t           state, state_next;
  logic [IDX_W-1:0] owner, last_grant, pick_grant;
  logic             pick_any, req_hs, rsp_hs;
  logic [CNT_W-1:0] cnt;
  logic [W_IN-1:0]  a_slice [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign a_slice[g] = req_a[g*W_IN +: W_IN];
  end

  log2_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state and the combinational request/response handshakes.
  always_comb begin
    state_next = state;
    req_ready  = '0;
    req_hs     = 1'b0;
    rsp_hs     = 1'b0;
    case (state)
      IDLE: begin
        if (rst && pick_any) begin
          req_ready  = N_REQ'(1) << pick_grant;
          req_hs     = req_valid[pick_grant];
          state_next = LOAD;
        end
      end
      LOAD: state_next = (core_a == '0) ? RESP : RUN;
      RUN: begin
        if (cnt == CNT_W'(LAT - 1)) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready[owner]) begin
          rsp_hs     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_a     <= '0;
      owner      <= '0;
      last_grant <= IDX_W'(N_REQ - 1);
      cnt        <= '0;
      rsp_o      <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= '0;
    end else begin
      core_rst  <= (state_next == LOAD);
      busy      <= (state_next != IDLE);
      rsp_valid <= (state_next == RESP) ? (N_REQ'(1) << owner) : '0;
      if (req_hs) begin
        core_a <= a_slice[pick_grant];
        owner  <= pick_grant;
      end
      case (state)
        LOAD: begin
          cnt <= '0;
          if (core_a == '0) rsp_o <= ZERO_RESULT;
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (state_next == RESP) rsp_o <= core_o;
        end
        RESP: begin
          if (rsp_hs) last_grant <= owner;
        end
        default: ;
      endcase
    end
  end

  // Grant and response vectors are never more than one-hot.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert ($onehot0(req_ready));
      assert ($onehot0(rsp_valid));
    end
  end

endmodule

// File: tb/tb_log2_arbiter.sv
// Directed bench for log2_arbiter with a behavioural log2X core that only
// presents a valid result once LAT-1 cycles have passed since restart.
module tb_log2_arbiter;
  import log2_arb_pkg::*;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned LAT   = 40;

  typedef struct {
    logic [3:0]  vmask;
    logic [31:0] a_bus;
    int          who;
    logic [10:0] rsp;
    int          lat;
    int          bp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a;
  logic [10:0] rsp_o, core_o;
  logic        core_rst, busy;
  logic [7:0]  core_a;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned sc = 0;
  vec_t vecs[12];

  always #5 clk = ~clk;

  log2_arbiter #(.N_REQ(N_REQ), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_o(rsp_o),
    .rsp_ready(rsp_ready), .core_rst(core_rst), .core_a(core_a),
    .core_o(core_o), .busy(busy)
  );

  // Hand-tabulated log2 results in 6.5 format for the operands used here.
  function automatic logic [10:0] core_log2(input logic [7:0] a);
    case (a)
      8'h78:   return 11'h07D;
      8'h08:   return 11'h000;
      8'h10:   return 11'h020;
      8'hF8:   return 11'h09E;
      8'h01:   return 11'h7A0;
      8'h04:   return 11'h7E0;
      default: return 11'h3C3;
    endcase
  endfunction

  always @(posedge clk) sc <= core_rst ? 0 : sc + 1;
  always_comb core_o = (!core_rst && sc >= LAT - 1) ? core_log2(core_a) : (11'h555 ^ 11'(sc));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Entered just after a negedge with the DUT in IDLE; returns likewise.
  task automatic do_op(input vec_t v);
    logic [3:0] exp_oh;
    logic [7:0] exp_a;
    logic [31:0] a_tmp;
    int k, pulses;
    logic ready_ok, hold_ok;
    exp_oh = 4'b0001 << v.who;
    a_tmp  = v.a_bus;
    exp_a  = a_tmp[v.who*8 +: 8];
    req_valid = v.vmask;
    req_a     = v.a_bus;
    rsp_ready = '0;
    #1;
    check("grant", 32'(req_ready), 32'(exp_oh));
    k = -1; pulses = 0; ready_ok = 1'b1;
    for (int c = 1; c <= int'(LAT) + 10; c++) begin
      @(negedge clk);
      if (c == 1) req_a = ~v.a_bus;
      #1;
      if (core_rst) pulses++;
      if (req_ready != 4'b0) ready_ok = 1'b0;
      if (rsp_valid != 4'b0) begin
        k = c;
        break;
      end
    end
    check("latency", 32'(k), 32'(v.lat));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_oh));
    check("rsp_o", 32'(rsp_o), 32'(v.rsp));
    check("core_a", 32'(core_a), 32'(exp_a));
    check("core_rst_pulses", 32'(pulses), 32'd1);
    check("ready_low_while_busy", 32'(ready_ok), 32'd1);
    if (v.bp > 0) begin
      hold_ok   = 1'b1;
      rsp_ready = 4'hF & ~exp_oh;
      for (int c = 0; c < v.bp; c++) begin
        @(negedge clk);
        #1;
        if (rsp_valid !== exp_oh || rsp_o !== v.rsp || req_ready !== 4'b0 || busy !== 1'b1)
          hold_ok = 1'b0;
      end
      check("backpressure_hold", 32'(hold_ok), 32'd1);
    end
    rsp_ready = exp_oh;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check("idle_after_resp", 32'({busy, rsp_valid}), 32'd0);
  endtask

  initial begin
    logic ok;
    // Contention 0,1,2,3,0 with all requests held.
    vecs[0]  = '{4'b1111, {8'h04, 8'h01, 8'h10, 8'h08}, 0, 11'h000, 42, 0};
    vecs[1]  = '{4'b1111, {8'h04, 8'h01, 8'h10, 8'h08}, 1, 11'h020, 42, 0};
    vecs[2]  = '{4'b1111, {8'h04, 8'h01, 8'h10, 8'h08}, 2, 11'h7A0, 42, 0};
    vecs[3]  = '{4'b1111, {8'h04, 8'h01, 8'h10, 8'h08}, 3, 11'h7E0, 42, 0};
    vecs[4]  = '{4'b1111, {8'h04, 8'h01, 8'h10, 8'h08}, 0, 11'h000, 42, 0};
    vecs[5]  = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'h78}, 0, 11'h07D, 42, 0};
    vecs[6]  = '{4'b0100, {8'hF8, 8'h00, 8'h10, 8'h08}, 2, 11'h7FF, 2, 0};
    vecs[7]  = '{4'b0110, {8'h00, 8'h08, 8'hF8, 8'h00}, 1, 11'h09E, 42, 10};
    vecs[8]  = '{4'b1010, {8'h10, 8'h00, 8'h78, 8'h00}, 3, 11'h020, 42, 0};
    vecs[9]  = '{4'b0011, {8'h00, 8'h00, 8'h78, 8'h01}, 0, 11'h7A0, 42, 0};
    vecs[10] = '{4'b0001, {8'h10, 8'h10, 8'h10, 8'h00}, 0, 11'h7FF, 2, 0};
    vecs[11] = '{4'b1111, {8'h04, 8'h01, 8'h10, 8'h08}, 0, 11'h000, 42, 0};

    rst = 1'b0; req_valid = 4'b1111; req_a = 32'h78787878; rsp_ready = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_o", 32'(rsp_o), 32'd0);
    check("reset_core_a", 32'(core_a), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_core_rst", 32'(core_rst), 32'd1);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    #1;

    for (int i = 0; i <= 10; i++) do_op(vecs[i]);

    // Reset while RUN is at count 20 for requester 2's operation.
    req_valid = 4'b0100;
    req_a     = {8'h00, 8'h78, 8'h00, 8'h00};
    #1;
    check("midrun_grant", 32'(req_ready), 32'b0100);
    repeat (22) @(negedge clk);
    #1;
    check("midrun_busy_before", 32'(busy), 32'd1);
    rst = 1'b0; req_valid = '0;
    @(negedge clk);
    #1;
    check("midrun_busy", 32'(busy), 32'd0);
    check("midrun_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrun_core_rst", 32'(core_rst), 32'd1);
    rst = 1'b1;
    ok = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 4'b0 || busy !== 1'b0) ok = 1'b0;
    end
    check("discarded_result_silent", 32'(ok), 32'd1);
    do_op(vecs[11]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
